// File: rtl/ffnn_load_infer_controller_pkg.sv
// Shared types and helpers for the FFNN load/infer controller.
// Covers the Q-format unit constant, the word counts per layer and the controller state encoding.
package ffnn_pkg;

   localparam logic [31:0] ONE = 32'h0001_0000;

   function automatic logic [63:0] q_one(input int unsigned w);
      return 64'd1 << (w / 2);
   endfunction

   function automatic int unsigned W1_WORDS(input int unsigned i, input int unsigned h,
                                            input int unsigned b);
      return (i + b) * h;
   endfunction

   function automatic int unsigned W2_WORDS(input int unsigned h, input int unsigned o,
                                            input int unsigned b);
      return (h + b) * o;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

endpackage

// File: rtl/ffnn_load_infer_controller_assembler.sv
// Byte-to-word assembler for NN weights: shifts little-endian bytes into a word and
// emits one registered write per word with its (layer, n, m) address in load order.
module ffnn_weight_word_assembler #(
   parameter int BITS_PER_WORD       = 32,
   parameter int INPUT_VECTOR_SIZE   = 2,
   parameter int HIDDEN_LAYER_SIZE   = 2,
   parameter int OUTPUT_VECTOR_SIZE  = 1,
   parameter int BIAS_SIZE           = 1,
   parameter int CLOG2_MAX_WEIGHTS_N = 2,
   parameter int CLOG2_MAX_WEIGHTS_M = 2
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           clear,
   input  logic                           byte_valid,
   input  logic [7:0]                     byte_data,
   output logic                           full,
   output logic                           word_valid,
   output logic                           word_last,
   output logic [BITS_PER_WORD-1:0]       word_data,
   output logic                           word_layer,
   output logic [CLOG2_MAX_WEIGHTS_N-1:0] word_n,
   output logic [CLOG2_MAX_WEIGHTS_M-1:0] word_m
);

   localparam int BPW = BITS_PER_WORD / 8;
   localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int NW  = CLOG2_MAX_WEIGHTS_N;
   localparam int MW  = CLOG2_MAX_WEIGHTS_M;

   logic [BCW-1:0]           byte_cnt;
   logic                     layer;
   logic [NW-1:0]            n;
   logic [MW-1:0]            m;
   logic [BITS_PER_WORD-1:0] shift;
   logic                     take;
   logic                     last_byte;
   logic                     n_last;
   logic                     m_last;

   assign take      = byte_valid && !full && !clear;
   assign last_byte = (byte_cnt == BCW'(BPW - 1));
   assign n_last    = layer ? (n == NW'(HIDDEN_LAYER_SIZE + BIAS_SIZE - 1))
                            : (n == NW'(INPUT_VECTOR_SIZE + BIAS_SIZE - 1));
   assign m_last    = layer ? (m == MW'(OUTPUT_VECTOR_SIZE - 1))
                            : (m == MW'(HIDDEN_LAYER_SIZE - 1));

   // Newest byte enters at the top, so after BPW bytes byte0 lands in bits [7:0].
   always_ff @(posedge clk) begin
      if (take)
         shift <= {byte_data, shift[BITS_PER_WORD-1:8]};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         byte_cnt   <= '0;
         layer      <= 1'b0;
         n          <= '0;
         m          <= '0;
         full       <= 1'b0;
         word_valid <= 1'b0;
         word_last  <= 1'b0;
         word_data  <= '0;
         word_layer <= 1'b0;
         word_n     <= '0;
         word_m     <= '0;
      end else begin
         word_valid <= 1'b0;
         word_last  <= 1'b0;
         if (clear) begin
            byte_cnt <= '0;
            layer    <= 1'b0;
            n        <= '0;
            m        <= '0;
            full     <= 1'b0;
         end else if (take) begin
            if (last_byte) begin
               byte_cnt   <= '0;
               word_valid <= 1'b1;
               word_data  <= {byte_data, shift[BITS_PER_WORD-1:8]};
               word_layer <= layer;
               word_n     <= n;
               word_m     <= m;
               // m is the inner index; layer 1 follows the last layer-0 row.
               if (layer && n_last && m_last) begin
                  word_last <= 1'b1;
                  full      <= 1'b1;
               end
               if (!m_last) begin
                  m <= m + 1'b1;
               end else begin
                  m <= '0;
                  if (!n_last) begin
                     n <= n + 1'b1;
                  end else begin
                     n     <= '0;
                     layer <= 1'b1;
                  end
               end
            end else begin
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ffnn_load_infer_controller.sv
// Sequencer in front of the NN: loads weights from a byte stream, then serves
// one inference request at a time and returns the captured NN result.
module ffnn_load_infer_controller
   import ffnn_pkg::*;
#(
   parameter int BITS_PER_WORD       = 32,
   parameter int INPUT_VECTOR_SIZE   = 2,
   parameter int HIDDEN_LAYER_SIZE   = 2,
   parameter int OUTPUT_VECTOR_SIZE  = 1,
   parameter int BIAS_SIZE           = 1,
   parameter int CLOG2_MAX_WEIGHTS_N = 2,
   parameter int CLOG2_MAX_WEIGHTS_M = 2,
   parameter int RESULT_LATENCY      = 1
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic                                        cfg_start,
   input  logic                                        cfg_valid,
   output logic                                        cfg_ready,
   input  logic [7:0]                                  cfg_byte,
   input  logic                                        req_valid,
   output logic                                        req_ready,
   input  logic [INPUT_VECTOR_SIZE-1:0]                req_data,
   output logic                                        resp_valid,
   input  logic                                        resp_ready,
   output logic [BITS_PER_WORD*OUTPUT_VECTOR_SIZE-1:0] resp_data,
   output logic                                        loaded,
   output logic [15:0]                                 infer_count,
   output logic                                        nn_weights_en,
   output logic                                        nn_weights_layer_address,
   output logic [CLOG2_MAX_WEIGHTS_N-1:0]              nn_weights_n_address,
   output logic [CLOG2_MAX_WEIGHTS_M-1:0]              nn_weights_m_address,
   output logic [BITS_PER_WORD-1:0]                    nn_weights_data,
   output logic                                        nn_in_en,
   output logic [INPUT_VECTOR_SIZE-1:0]                nn_in_data,
   input  logic [BITS_PER_WORD*OUTPUT_VECTOR_SIZE-1:0] nn_out_data
);

   localparam int LCW = $clog2(RESULT_LATENCY + 1);

   state_t         state;
   state_t         state_nxt;
   logic [LCW-1:0] wait_cnt;
   logic           asm_full;
   logic           word_last;
   logic           wait_done;

   ffnn_weight_word_assembler #(
      .BITS_PER_WORD      (BITS_PER_WORD),
      .INPUT_VECTOR_SIZE  (INPUT_VECTOR_SIZE),
      .HIDDEN_LAYER_SIZE  (HIDDEN_LAYER_SIZE),
      .OUTPUT_VECTOR_SIZE (OUTPUT_VECTOR_SIZE),
      .BIAS_SIZE          (BIAS_SIZE),
      .CLOG2_MAX_WEIGHTS_N(CLOG2_MAX_WEIGHTS_N),
      .CLOG2_MAX_WEIGHTS_M(CLOG2_MAX_WEIGHTS_M)
   ) u_asm (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (cfg_start),
      .byte_valid(cfg_valid && (state == ST_LOAD)),
      .byte_data (cfg_byte),
      .full      (asm_full),
      .word_valid(nn_weights_en),
      .word_last (word_last),
      .word_data (nn_weights_data),
      .word_layer(nn_weights_layer_address),
      .word_n    (nn_weights_n_address),
      .word_m    (nn_weights_m_address)
   );

   assign cfg_ready = (state == ST_LOAD) && !asm_full;
   assign req_ready = (state == ST_READY);
   assign nn_in_en  = (state == ST_ISSUE);
   assign wait_done = (wait_cnt == LCW'(RESULT_LATENCY));

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cfg_start) begin
         state_nxt = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD:  if (nn_weights_en && word_last) state_nxt = ST_READY;
            ST_READY: if (req_valid)                  state_nxt = ST_ISSUE;
            ST_ISSUE:                                 state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_done)                  state_nxt = ST_RESP;
            ST_RESP:  if (resp_ready)                 state_nxt = ST_READY;
            default:                                  state_nxt = state;
         endcase
      end
   end

   // A reload drops any request in flight without counting it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         loaded      <= 1'b0;
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         nn_in_data  <= '0;
         infer_count <= '0;
         wait_cnt    <= '0;
      end else if (cfg_start) begin
         loaded     <= 1'b0;
         resp_valid <= 1'b0;
      end else begin
         case (state)
            ST_LOAD:  if (nn_weights_en && word_last) loaded <= 1'b1;
            ST_READY: if (req_valid) nn_in_data <= req_data;
            ST_ISSUE: wait_cnt <= LCW'(1);
            ST_WAIT: begin
               if (wait_done) begin
                  resp_data  <= nn_out_data;
                  resp_valid <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid  <= 1'b0;
                  infer_count <= infer_count + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ffnn_load_infer_controller.sv
// Directed bench for ffnn_load_infer_controller with a behavioural XOR network attached.
module tb_ffnn_load_infer_controller;

   typedef struct packed {
      logic        layer;
      logic [1:0]  n;
      logic [1:0]  m;
      logic [31:0] data;
   } wvec_t;

   typedef struct packed {
      logic [1:0]  req;
      logic [31:0] resp;
   } ivec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_start, cfg_valid, cfg_ready;
   logic [7:0]  cfg_byte;
   logic        req_valid, req_ready;
   logic [1:0]  req_data;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic        loaded;
   logic [15:0] infer_count;
   logic        nn_weights_en, nn_weights_layer_address;
   logic [1:0]  nn_weights_n_address, nn_weights_m_address;
   logic [31:0] nn_weights_data;
   logic        nn_in_en;
   logic [1:0]  nn_in_data;
   logic [31:0] nn_out_data = '0;

   int checks = 0;
   int failures = 0;
   int in_en_cnt = 0;
   wvec_t seen[$];
   wvec_t wtab[9];
   ivec_t itab[4];
   int signed w1[4][4];
   int signed w2[4];

   always #5 clk = ~clk;

   ffnn_load_infer_controller dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_byte(cfg_byte),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .loaded(loaded), .infer_count(infer_count),
      .nn_weights_en(nn_weights_en), .nn_weights_layer_address(nn_weights_layer_address),
      .nn_weights_n_address(nn_weights_n_address), .nn_weights_m_address(nn_weights_m_address),
      .nn_weights_data(nn_weights_data),
      .nn_in_en(nn_in_en), .nn_in_data(nn_in_data), .nn_out_data(nn_out_data)
   );

   // Behavioural NN: ReLU hidden layer, row 0 of each layer is the bias, Q16.16 weights.
   function automatic logic [31:0] nn_model(input logic [1:0] x);
      longint h[2];
      longint y;
      for (int j = 0; j < 2; j++) begin
         h[j] = longint'(w1[0][j]);
         if (x[0]) h[j] += longint'(w1[1][j]);
         if (x[1]) h[j] += longint'(w1[2][j]);
         if (h[j] < 0) h[j] = 0;
      end
      y = longint'(w2[0]) + ((h[0] * longint'(w2[1]) + h[1] * longint'(w2[2])) >>> 16);
      return y[31:0];
   endfunction

   always @(posedge clk) begin
      if (nn_weights_en) begin
         if (!nn_weights_layer_address)
            w1[nn_weights_n_address][nn_weights_m_address] <= nn_weights_data;
         else
            w2[nn_weights_n_address] <= nn_weights_data;
      end
      if (nn_in_en)
         nn_out_data <= nn_model(nn_in_data);
   end

   always @(negedge clk) begin
      if (nn_weights_en)
         seen.push_back({nn_weights_layer_address, nn_weights_n_address,
                         nn_weights_m_address, nn_weights_data});
      if (nn_in_en)
         in_en_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k = 0;
      cfg_valid = 1'b1;
      cfg_byte  = b;
      while (!cfg_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) timeout("cfg_ready");
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic load_words(input int nbytes);
      for (int i = 0; i < nbytes; i++)
         send_byte(wtab[i / 4].data[8 * (i % 4) +: 8]);
   endtask

   task automatic wait_loaded();
      int k = 0;
      while (!loaded && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("loaded", loaded, 1);
   endtask

   task automatic pulse_cfg_start(input logic with_byte);
      cfg_start = 1'b1;
      cfg_valid = with_byte;
      cfg_byte  = 8'hAA;
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
   endtask

   task automatic do_req(input logic [1:0] x);
      int k = 0;
      req_valid = 1'b1;
      req_data  = x;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) timeout("req_ready");
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      int k = 0;
      while (!resp_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k == 50) timeout("resp_valid");
   endtask

   initial begin
      int ic;
      int base;
      logic ok_v, ok_d, ok_r;

      wtab[0] = '{1'b0, 2'd0, 2'd0, 32'h0000_0000};
      wtab[1] = '{1'b0, 2'd0, 2'd1, 32'hFFFF_0000};
      wtab[2] = '{1'b0, 2'd1, 2'd0, 32'h0001_0000};
      wtab[3] = '{1'b0, 2'd1, 2'd1, 32'h0001_0000};
      wtab[4] = '{1'b0, 2'd2, 2'd0, 32'h0001_0000};
      wtab[5] = '{1'b0, 2'd2, 2'd1, 32'h0001_0000};
      wtab[6] = '{1'b1, 2'd0, 2'd0, 32'h0000_0000};
      wtab[7] = '{1'b1, 2'd1, 2'd0, 32'h0001_0000};
      wtab[8] = '{1'b1, 2'd2, 2'd0, 32'hFFFE_0000};
      itab[0] = '{2'b00, 32'h0000_0000};
      itab[1] = '{2'b01, 32'h0001_0000};
      itab[2] = '{2'b10, 32'h0001_0000};
      itab[3] = '{2'b11, 32'h0000_0000};

      reset_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_byte = '0;
      req_valid = 1'b0; req_data = '0; resp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_outputs",
          {cfg_ready, req_ready, resp_valid, loaded, nn_weights_en, nn_in_en, nn_in_data},
          '0);
      chk("rst_infer_count", infer_count, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_nn_weights", {nn_weights_layer_address, nn_weights_n_address,
                             nn_weights_m_address, nn_weights_data}, 0);

      // IDLE ignores bytes until cfg_start
      reset_n = 1'b1;
      cfg_valid = 1'b1; cfg_byte = 8'h55;
      repeat (3) @(negedge clk);
      chk("idle_cfg_ready", cfg_ready, 0);
      chk("idle_no_write", seen.size(), 0);
      cfg_valid = 1'b0;

      pulse_cfg_start(1'b0);
      chk("load_cfg_ready", cfg_ready, 1);
      load_words(35);
      chk("loaded_before_last", loaded, 0);
      load_words(0);
      send_byte(wtab[8].data[31:24]);
      wait_loaded();
      chk("write_count", seen.size(), 9);
      for (int i = 0; i < 9; i++)
         if (i < seen.size()) chk($sformatf("write_%0d", i), seen[i], wtab[i]);
      chk("ready_cfg_ready", cfg_ready, 0);
      chk("ready_req_ready", req_ready, 1);

      for (int i = 0; i < 4; i++) begin
         do_req(itab[i].req);
         wait_resp();
         chk($sformatf("resp_%0d", i), resp_data, itab[i].resp);
         chk($sformatf("busy_req_ready_%0d", i), req_ready, 0);
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
         chk($sformatf("resp_clr_%0d", i), {resp_valid, req_ready}, 2'b01);
      end
      chk("infer_count_4", infer_count, 4);
      chk("in_en_count_4", in_en_cnt, 4);

      // Back-pressure on the response
      base = in_en_cnt;
      do_req(2'b01);
      wait_resp();
      ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (resp_valid !== 1'b1) ok_v = 1'b0;
         if (resp_data !== 32'h0001_0000) ok_d = 1'b0;
         if (req_ready !== 1'b0) ok_r = 1'b0;
      end
      chk("hold_resp_valid", ok_v, 1);
      chk("hold_resp_data", ok_d, 1);
      chk("hold_req_ready", ok_r, 1);
      chk("hold_in_en_once", in_en_cnt - base, 1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("infer_count_5", infer_count, 5);

      // Reload aborted mid-word, then a full reload
      pulse_cfg_start(1'b0);
      chk("reload_loaded", loaded, 0);
      chk("reload_cfg_ready", cfg_ready, 1);
      load_words(10);
      pulse_cfg_start(1'b1);
      seen.delete();
      chk("abort_loaded", loaded, 0);
      load_words(36);
      wait_loaded();
      chk("reload_count", seen.size(), 9);
      if (seen.size() == 9) begin
         chk("reload_word0", seen[0], wtab[0]);
         chk("reload_word8", seen[8], wtab[8]);
      end

      // cfg_start while waiting on the NN result
      ic = infer_count;
      do_req(2'b01);
      @(negedge clk);
      pulse_cfg_start(1'b0);
      ok_v = 1'b1;
      repeat (10) begin
         if (resp_valid !== 1'b0) ok_v = 1'b0;
         @(negedge clk);
      end
      chk("wait_abort_resp_valid", ok_v, 1);
      chk("wait_abort_count", infer_count, ic);
      chk("wait_abort_state", {cfg_ready, req_ready, loaded}, 3'b100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
